// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Program-counter / fetch sequencer for the 9-bit-instruction core.
//   Produces the instruction-ROM address every cycle, applies relative
//   branches selected from an 8-entry signed offset table, and owns the
//   Start/Done run-control handshake.
//
// Parameters
//   PC_W         width of the program counter / ROM address
//   LUT_OFFSETS  packed 8 x 8-bit signed branch offsets, entry k = [8k+7:8k]
//
// Ports
//   CLK          in   system clock, rising edge
//   Reset        in   synchronous active-high reset (highest priority)
//   Start        in   one-cycle pulse, begin execution at address 0
//   Instruction  in   current machine word; [5:3] selects the branch offset
//   branch_en    in   take branch this cycle (from decoder)
//   halt_req     in   current instruction is halt (from decoder)
//   PC           out  instruction-ROM address
//   Busy         out  high while running
//   Done         out  high while halted, held until Start or Reset
//   pc_overflow  out  sticky: sequential advance ran off the end of ROM
//   cycle_cnt    out  (FETCH_PERF_CNT_EN only) saturating RUN-cycle count
//   taken_cnt    out  (FETCH_PERF_CNT_EN only) saturating taken-branch count
//
// Build option
//   FETCH_PERF_CNT_EN  when defined, adds the cycle_cnt / taken_cnt counters.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned PC_W        = 10,
  parameter logic [63:0] LUT_OFFSETS = {8{8'sd0}}
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      Instruction,
  input  logic            branch_en,
  input  logic            halt_req,
  output logic [PC_W-1:0] PC,
  output logic            Busy,
  output logic            Done,
  output logic            pc_overflow
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     cycle_cnt,
  output logic [15:0]     taken_cnt
`endif
);

  // Offsets are sign-extended into at least 8 bits so narrow PCs still wrap
  // correctly after truncation.
  localparam int unsigned EXT_W = (PC_W > 8) ? PC_W : 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t            state_r;
  state_t            state_n_s;
  logic [PC_W-1:0]   pc_r;
  logic [PC_W-1:0]   pc_n_s;
  logic              ovf_r;
  logic              ovf_n_s;
  logic              busy_r;
  logic              done_r;

  logic signed [7:0] off_s;
  logic [EXT_W-1:0]  off_ext_s;
  logic [EXT_W-1:0]  sum_s;
  logic [PC_W-1:0]   target_s;
  logic              taken_s;
  logic              run_cyc_s;

  // Only the LUT index field of the instruction matters to this block.
  logic unused_s;
  assign unused_s = &{1'b0, Instruction[8:6], Instruction[2:0]};

  // Branch target: PC plus the sign-extended table offset, modulo 2^PC_W.
  always_comb begin
    off_s     = LUT_OFFSETS[{Instruction[5:3], 3'b000} +: 8];
    off_ext_s = EXT_W'(off_s);
    sum_s     = EXT_W'(pc_r) + off_ext_s;
    target_s  = sum_s[PC_W-1:0];
  end

  // Next-state / next-PC decision in priority order Start > halt > branch > step.
  always_comb begin
    state_n_s = state_r;
    pc_n_s    = pc_r;
    ovf_n_s   = ovf_r;
    taken_s   = 1'b0;
    run_cyc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pc_n_s = {PC_W{1'b0}};
        if (Start) begin
          state_n_s = ST_RUN;
          ovf_n_s   = 1'b0;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        run_cyc_s = ~Start;
        if (Start) begin
          pc_n_s  = {PC_W{1'b0}};
          ovf_n_s = 1'b0;
        end else if (halt_req) begin
          state_n_s = ST_HALTED;
        end else if (branch_en) begin
          pc_n_s  = target_s;
          taken_s = 1'b1;
        end else if (pc_r != {PC_W{1'b1}}) begin
          pc_n_s = pc_r + PC_W'(1'b1);
        end else begin
          // Sequential fetch past the last ROM word: stop instead of wrapping.
          state_n_s = ST_HALTED;
          ovf_n_s   = 1'b1;
        end
      end
      ST_HALTED: begin
        if (Start) begin
          state_n_s = ST_RUN;
          pc_n_s    = {PC_W{1'b0}};
          ovf_n_s   = 1'b0;
        end else begin
          state_n_s = ST_HALTED;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        pc_n_s    = {PC_W{1'b0}};
        ovf_n_s   = 1'b0;
      end
    endcase
  end

  // State, PC and status registers; Busy/Done are registered from next state
  // so they line up exactly with the state register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      pc_r    <= {PC_W{1'b0}};
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      pc_r    <= pc_n_s;
      ovf_r   <= ovf_n_s;
      busy_r  <= (state_n_s == ST_RUN);
      done_r  <= (state_n_s == ST_HALTED);
    end
  end

  assign PC          = pc_r;
  assign Busy        = busy_r;
  assign Done        = done_r;
  assign pc_overflow = ovf_r;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cycle_cnt_r;
  logic [15:0] taken_cnt_r;

  // Saturating performance counters, cleared by Reset and by any Start.
  always_ff @(posedge CLK) begin
    if (Reset || Start) begin
      cycle_cnt_r <= 16'h0000;
      taken_cnt_r <= 16'h0000;
    end else begin
      if (run_cyc_s && (cycle_cnt_r != 16'hFFFF)) begin
        cycle_cnt_r <= cycle_cnt_r + 16'h0001;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if (taken_s && (taken_cnt_r != 16'hFFFF)) begin
        taken_cnt_r <= taken_cnt_r + 16'h0001;
      end else begin
        taken_cnt_r <= taken_cnt_r;
      end
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign taken_cnt = taken_cnt_r;
`else
  logic unused_perf_s;
  assign unused_perf_s = &{1'b0, taken_s, run_cyc_s};
`endif

endmodule
